// File: rtl/booth_keypad_ctrl.sv
// rtl/booth_keypad_ctrl.sv - keypad operand entry (two 2-digit BCD numbers) feeding a radix-2 Booth multiplier
// Optional macro KEY_DEBOUNCE_EN: require 4 cycles of key stability before a pattern counts.

module bcd_keypad_enc (
    input  logic [9:0] key,
    output logic [3:0] bcd
);
    always_comb begin
        bcd = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key[i]) bcd = i[3:0];
        end
    end
endmodule

module booth_keypad_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  key,
    input  logic        start,
    input  logic        ack,
    output logic [15:0] prod,
    output logic        done,
    output logic        busy,
    output logic [3:0]  digit,
    output logic        err
);
    typedef enum logic [2:0] {
        S_IDLE, S_GET_A1, S_GET_A0, S_GET_B1, S_GET_B0, S_MULT, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  key_q, key_prev_q, key_prev_d, key_cur;
    logic [3:0]  tens_q, tens_d;
    logic [7:0]  m_q, m_d, acc_q, acc_d, q_q, q_d;
    logic        q1_q, q1_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] prod_q, prod_d;
    logic        done_q, done_d, busy_q, busy_d, err_q, err_d;
    logic [3:0]  digit_q, digit_d, enc_bcd;
    logic        in_entry, press_edge, one_hot, accept, illegal;
    logic [7:0]  acc_sum, operand;

`ifdef KEY_DEBOUNCE_EN
    logic [1:0]  deb_cnt_q, deb_cnt_d;
    logic [9:0]  filt_q, filt_d;

    // A pattern is promoted once key_q has matched the raw input for 4 samples.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        filt_d    = filt_q;
        if (key != key_q) begin
            deb_cnt_d = 2'd0;
        end else begin
            if (deb_cnt_q != 2'd3) deb_cnt_d = deb_cnt_q + 2'd1;
            if (deb_cnt_q >= 2'd2) filt_d = key_q;
        end
    end
    assign key_cur = filt_q;
`else
    assign key_cur = key_q;
`endif

    bcd_keypad_enc u_enc (
        .key (key_cur),
        .bcd (enc_bcd)
    );

    assign in_entry   = (state_q == S_GET_A1) || (state_q == S_GET_A0) ||
                        (state_q == S_GET_B1) || (state_q == S_GET_B0);
    assign press_edge = (key_prev_q == 10'd0) && (key_cur != 10'd0);
    assign one_hot    = ((key_cur & (key_cur - 10'd1)) == 10'd0);
    assign accept     = in_entry && press_edge && one_hot;
    assign illegal    = in_entry && press_edge && !one_hot;
    assign key_prev_d = key_cur;

    // tens*10 + units, built from shifts
    assign operand = {1'b0, tens_q, 3'b000} + {3'b000, tens_q, 1'b0} + {4'b0000, enc_bcd};

    always_comb begin
        case ({q_q[0], q1_q})
            2'b01:   acc_sum = acc_q + m_q;
            2'b10:   acc_sum = acc_q - m_q;
            default: acc_sum = acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        done_d  = done_q;
        digit_d = digit_q;
        err_d   = illegal;
        if (accept) digit_d = enc_bcd;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_GET_A1;
                    prod_d  = 16'd0;
                end
            end
            S_GET_A1: if (accept) begin
                tens_d  = enc_bcd;
                state_d = S_GET_A0;
            end
            S_GET_A0: if (accept) begin
                m_d     = operand;
                state_d = S_GET_B1;
            end
            S_GET_B1: if (accept) begin
                tens_d  = enc_bcd;
                state_d = S_GET_B0;
            end
            S_GET_B0: if (accept) begin
                acc_d   = 8'd0;
                q_d     = operand;
                q1_d    = 1'b0;
                cnt_d   = 3'd0;
                state_d = S_MULT;
            end
            S_MULT: begin
                // arithmetic right shift of {ACC, Q, Q-1}
                acc_d = {acc_sum[7], acc_sum[7:1]};
                q_d   = {acc_sum[0], q_q[7:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    prod_d  = {acc_sum[7], acc_sum[7:1], acc_sum[0], q_q[7:1]};
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ack) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            key_q      <= 10'd0;
            key_prev_q <= 10'd0;
            tens_q     <= 4'd0;
            m_q        <= 8'd0;
            acc_q      <= 8'd0;
            q_q        <= 8'd0;
            q1_q       <= 1'b0;
            cnt_q      <= 3'd0;
            prod_q     <= 16'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            digit_q    <= 4'd0;
            err_q      <= 1'b0;
`ifdef KEY_DEBOUNCE_EN
            deb_cnt_q  <= 2'd0;
            filt_q     <= 10'd0;
`endif
        end else begin
            state_q    <= state_d;
            key_q      <= key;
            key_prev_q <= key_prev_d;
            tens_q     <= tens_d;
            m_q        <= m_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            q1_q       <= q1_d;
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            digit_q    <= digit_d;
            err_q      <= err_d;
`ifdef KEY_DEBOUNCE_EN
            deb_cnt_q  <= deb_cnt_d;
            filt_q     <= filt_d;
`endif
        end
    end

    assign prod  = prod_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign digit = digit_q;
    assign err   = err_q;
endmodule

// File: tb/tb_booth_keypad_ctrl.sv
// tb/tb_booth_keypad_ctrl.sv - directed and randomized checks of booth_keypad_ctrl against arithmetic expectations

module tb_booth_keypad_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [9:0]  key = 10'd0;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] prod;
    logic        done, busy, err;
    logic [3:0]  digit;

    int checks = 0;
    int failures = 0;

    booth_keypad_ctrl dut (
        .CLK   (CLK),
        .RST   (RST),
        .key   (key),
        .start (start),
        .ack   (ack),
        .prod  (prod),
        .done  (done),
        .busy  (busy),
        .digit (digit),
        .err   (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic press(input int d, input int hold, input int rel);
        key = 10'd1 << d;
        tick(hold);
        key = 10'd0;
        tick(rel);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("prod_cleared", prod, 0);
    endtask

    // Presses the final digit and checks done appears exactly 9 cycles after the accept cycle.
    task automatic last_key(input int d, input int exp_prod);
        key = 10'd1 << d;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i == 2) key = 10'd0;
            if (i == 9) chk("done_not_early", done, 0);
            if (i == 10) chk("done_on_time", done, 1);
        end
        chk("prod", prod, exp_prod);
        chk("digit_last", digit, d);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("busy_after_ack", busy, 0);
        chk("done_after_ack", done, 0);
    endtask

    task automatic run_txn(input int a1, input int a0, input int b1, input int b0);
        int expected;
        expected = (a1 * 10 + a0) * (b1 * 10 + b0);
        do_start();
        press(a1, 2, 2);
        chk("digit_a1", digit, a1);
        press(a0, 2, 2);
        chk("digit_a0", digit, a0);
        press(b1, 2, 2);
        chk("digit_b1", digit, b1);
        last_key(b0, expected);
        do_ack();
    endtask

    initial begin
        int d[4];
        tick(2);
        RST = 1'b0;
        chk("rst_prod", prod, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_digit", digit, 0);
        chk("rst_err", err, 0);

`ifdef KEY_DEBOUNCE_EN
        do_start();
        press(5, 2, 6);
        chk("deb_glitch_ignored", digit, 0);
        press(5, 6, 6);
        chk("deb_press_accepted", digit, 5);
`else
        // keys pressed in IDLE are ignored
        press(7, 2, 2);
        chk("idle_key_ignored", digit, 0);
        chk("idle_busy", busy, 0);

        run_txn(1, 2, 3, 4);
        run_txn(9, 9, 9, 9);
        run_txn(0, 0, 5, 7);

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 4; k++) d[k] = $urandom_range(0, 9);
            run_txn(d[0], d[1], d[2], d[3]);
        end

        // two keys at once in GET_A0: one-cycle err, no state change
        do_start();
        press(4, 2, 2);
        key = 10'h006;
        tick(1);
        chk("err_not_yet", err, 0);
        tick(1);
        chk("err_pulse", err, 1);
        chk("err_digit_kept", digit, 4);
        tick(1);
        chk("err_one_cycle", err, 0);
        key = 10'd0;
        tick(2);
        press(6, 2, 2);
        chk("digit_after_err", digit, 6);
        press(1, 2, 2);
        last_key(1, 46 * 11);
        do_ack();

        // reset during the 4th MULT cycle
        do_start();
        press(5, 2, 2);
        press(5, 2, 2);
        press(5, 2, 2);
        key = 10'd1 << 5;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            if (i == 2) key = 10'd0;
        end
        chk("mult_busy", busy, 1);
        chk("mult_done", done, 0);
        RST = 1'b1;
        start = 1'b1;
        ack = 1'b1;
        tick(1);
        RST = 1'b0;
        start = 1'b0;
        ack = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_prod", prod, 0);
        chk("midrst_digit", digit, 0);
        run_txn(0, 3, 0, 2);

        // DONE holds through key noise and ignores start when acked
        do_start();
        press(2, 2, 2);
        press(5, 2, 2);
        press(4, 2, 2);
        last_key(0, 25 * 40);
        for (int i = 0; i < 20; i++) begin
            key = 10'($urandom_range(0, 1023));
            tick(1);
            chk("hold_prod", prod, 1000);
            chk("hold_done", done, 1);
        end
        key = 10'd0;
        ack = 1'b1;
        start = 1'b1;
        tick(1);
        ack = 1'b0;
        start = 1'b0;
        chk("ackstart_busy", busy, 0);
        chk("ackstart_done", done, 0);
        tick(1);
        chk("ackstart_stay_idle", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
